slice_add_arb: RTL
==================

SLICE_ADD_ARB -- requirements
Module: slice_add_arb

Interface
REQ-001 SLICE_W, default 1: width in bits of each operand slice, legal 1..4.
REQ-002 CLK  input  1  single clock, all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 LO_A  input  3  low bit index of slice taken from the A operand.
REQ-005 LO_B  input  3  low bit index of slice taken from the B operand.
REQ-006 R0_VALID  input  1  requester 0 has an operand pair.
REQ-007 R0_A, R0_B  input  8 each  requester 0 operands, sint(8).
REQ-008 R0_READY  output  1  requester 0 pair accepted this cycle.
REQ-009 R1_VALID, R1_A, R1_B, R1_READY: same as REQ-006..008 for requester 1.
REQ-010 OUT_VALID  output  1  result register holds a valid result.
REQ-011 OUT_DATA  output  4  result, sint(4).
REQ-012 OUT_ID  output  1  index of the requester that produced OUT_DATA.
REQ-013 OUT_READY  input  1  consumer accepts the result this cycle.

Function
REQ-014 Slice: A[LO_A+SLICE_W-1 : LO_A] and the B equivalent, each zero-extended (part-select is unsigned) to 4 bits.
REQ-015 Result = sum of the two extended slices, truncated modulo 16, reinterpreted as sint(4); no saturation, no overflow flag.
REQ-016 Slice bits beyond bit 7 (LO+SLICE_W > 8) read as 0.
REQ-017 LO_A/LO_B sampled in the accept cycle; later changes do not alter a captured result.
REQ-018 Output slot "free" = !OUT_VALID || OUT_READY.
REQ-019 Arbitration only when the slot is free; at most one READY high per cycle; READY never high when slot not free.
REQ-020 Single requester valid: that requester granted.
REQ-021 Both valid: grant the requester indicated by round-robin pointer PRI; PRI then points to the other requester.
REQ-022 PRI updates only on a grant; a single-request grant also sets PRI to the non-granted requester.
REQ-023 Grant: READY high combinationally in that cycle; OUT_DATA/OUT_ID/OUT_VALID=1 registered at next edge (latency 1 cycle).
REQ-024 Sustained throughput one result per cycle while OUT_READY held high.
REQ-025 OUT_VALID high and OUT_READY low: OUT_DATA, OUT_ID held stable, both READYs low.
REQ-026 OUT_READY high and no request: OUT_VALID cleared next edge.
REQ-027 Requesters hold VALID and operands until READY; the block does not check this.
REQ-028 States: EMPTY (OUT_VALID=0), FULL (OUT_VALID=1); EMPTY->FULL on grant; FULL->EMPTY on OUT_READY without grant; FULL->FULL on OUT_READY with grant or on stall.

Reset
REQ-029 RST high: OUT_VALID=0, OUT_DATA=0, OUT_ID=0, PRI=0 (requester 0 first), state EMPTY, immediately and asynchronously.
REQ-030 READY outputs low while RST high; a result in flight at reset is discarded, not delivered.
REQ-031 First grant possible in the first rising edge after RST deasserts.

Structure
REQ-032 Shared package slice_arb_pkg: state enum (EMPTY, FULL), operand width 8, result width 4, requester count 2.
REQ-033 Sub-module slice_add: combinational slice extract + modulo-16 add, ports A, B, LO_A, LO_B, XOUT, parameter SLICE_W.
REQ-034 Arbiter, PRI and output register live in slice_add_arb.

Verification
REQ-035 SLICE_W=1, LO_A=0, LO_B=1, R0 only: A=0x01, B=0x02, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_DATA=2, OUT_ID=0.
REQ-036 SLICE_W=4, LO_A=0, LO_B=4: A=0x0F, B=0xF0 -> OUT_DATA=0xE (-2), wrap modulo 16 confirmed.
REQ-037 Both valid for 4 cycles, OUT_READY=1, after reset -> OUT_ID sequence 0,1,0,1; one READY per cycle.
REQ-038 Result FULL, OUT_READY=0 for 3 cycles with both requesting -> OUT_DATA/OUT_ID stable, R0_READY=R1_READY=0; OUT_READY=1 -> next result delivered following cycle.
REQ-039 SLICE_W=3, LO_A=6: A=0xC0 -> A slice reads 0b011 (bit 8 as 0), OUT_DATA=3 with B slice 0.
REQ-040 RST asserted mid-stream with OUT_VALID=1 -> OUT_VALID=0 without a clock edge; after release, R1 alone requesting is granted, then with both valid R0 wins.

Source files
------------

// File: rtl/slice_add_arb_pkg.sv
// Shared types and sizes for the slice-add arbiter slice.
// Contents: output register state enum, operand/result/index widths, requester count.
// No logic; imported by slice_add and slice_add_arb.
package slice_arb_pkg;

  localparam int OP_W  = 8;               // operand width, sint(8)
  localparam int RES_W = 4;               // result width, sint(4)
  localparam int LO_W  = 3;               // slice low-index width
  localparam int N_REQ = 2;               // requester count
  localparam int ID_W  = $clog2(N_REQ);   // requester index width

  typedef logic [ID_W-1:0] req_id_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/slice_add_arb_add.sv
// slice_add: combinational slice extract and modulo-16 add.
// Ports: A, B operands; LO_A, LO_B slice low indices; XOUT = zext(A slice) + zext(B slice) mod 16.
// Latency 0; no flow control.
module slice_add
  import slice_arb_pkg::*;
#(
  parameter int SLICE_W = 1
) (
  input  logic [OP_W-1:0]  A,
  input  logic [OP_W-1:0]  B,
  input  logic [LO_W-1:0]  LO_A,
  input  logic [LO_W-1:0]  LO_B,
  output logic [RES_W-1:0] XOUT
);

  localparam logic [RES_W-1:0] SLICE_MASK = RES_W'((1 << SLICE_W) - 1);

  // A right shift pulls zeros in from the top, so slice bits past bit 7
  // read as 0 without any extra range check.
  logic [RES_W-1:0] a_sl;
  logic [RES_W-1:0] b_sl;

  assign a_sl = RES_W'(A >> LO_A) & SLICE_MASK;
  assign b_sl = RES_W'(B >> LO_B) & SLICE_MASK;

  // 4-bit add wraps modulo 16; the bit pattern is the sint(4) result.
  assign XOUT = a_sl + b_sl;

endmodule

// File: rtl/slice_add_arb.sv
// slice_add_arb: two-requester round-robin arbiter feeding a slice adder into a one-deep result register.
// Ports: CLK/RST (async active-high), LO_A/LO_B, R0_*/R1_* valid-ready requesters, OUT_* valid-ready result.
// Latency 1 cycle grant-to-OUT_VALID; READY only when the result slot is free (empty or being drained).
module slice_add_arb
  import slice_arb_pkg::*;
#(
  parameter int SLICE_W = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [LO_W-1:0]  LO_A,
  input  logic [LO_W-1:0]  LO_B,
  input  logic             R0_VALID,
  input  logic [OP_W-1:0]  R0_A,
  input  logic [OP_W-1:0]  R0_B,
  output logic             R0_READY,
  input  logic             R1_VALID,
  input  logic [OP_W-1:0]  R1_A,
  input  logic [OP_W-1:0]  R1_B,
  output logic             R1_READY,
  output logic             OUT_VALID,
  output logic [RES_W-1:0] OUT_DATA,
  output logic [ID_W-1:0]  OUT_ID,
  input  logic             OUT_READY
);

  out_state_t       state_q, state_d;
  logic [RES_W-1:0] out_data_q, out_data_d;
  req_id_t          out_id_q, out_id_d;
  req_id_t          pri_q, pri_d;

  logic             slot_free;
  logic             gnt_vld;
  req_id_t          gnt_id;
  logic [OP_W-1:0]  op_a;
  logic [OP_W-1:0]  op_b;
  logic [RES_W-1:0] sum;

  // Only the granted pair reaches the adder, so one adder serves both requesters.
  slice_add #(
    .SLICE_W (SLICE_W)
  ) u_add (
    .A    (op_a),
    .B    (op_b),
    .LO_A (LO_A),
    .LO_B (LO_B),
    .XOUT (sum)
  );

  always_comb begin
    slot_free  = (state_q == EMPTY) || OUT_READY;
    gnt_vld    = 1'b0;
    gnt_id     = '0;
    state_d    = state_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    pri_d      = pri_q;

    // Gate with RST so no requester sees an accept during reset.
    if (slot_free && !RST) begin
      if (R0_VALID && R1_VALID) begin
        gnt_vld = 1'b1;
        gnt_id  = pri_q;
      end else if (R0_VALID) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (R1_VALID) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end

    op_a = gnt_id ? R1_A : R0_A;
    op_b = gnt_id ? R1_B : R0_B;

    if (gnt_vld) begin
      state_d    = FULL;
      out_data_d = sum;
      out_id_d   = gnt_id;
      // Any grant, contended or not, hands priority to the other requester.
      pri_d      = ~gnt_id;
    end else if (OUT_READY) begin
      state_d    = EMPTY;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_id_q   <= '0;
      pri_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      pri_q      <= pri_d;
    end
  end

  assign R0_READY  = gnt_vld && (gnt_id == 1'b0);
  assign R1_READY  = gnt_vld && (gnt_id == 1'b1);
  assign OUT_VALID = (state_q == FULL);
  assign OUT_DATA  = out_data_q;
  assign OUT_ID    = out_id_q;

endmodule
